mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; the block has one clock.
REQ-004 start  input  1  request a multiplication; sampled on the rising edge of clk.
REQ-005 signed_mode  input  1  0 = unsigned operands; 1 = two's-complement operands.
REQ-006 a  input  WIDTH  multiplicand; sampled with start.
REQ-007 b  input  WIDTH  multiplier; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; marks the cycle in which results are updated.
REQ-010 result  output  WIDTH  low WIDTH bits of the product; same truncation as the existing MUL.
REQ-011 result_full  output  2*WIDTH  full-width product.
REQ-012 overflow  output  1  product not representable in WIDTH bits under the current mode.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, FIX, DONE.
REQ-014 IDLE, start=1: latch a, b and signed_mode; go to RUN; iteration counter = 0.
REQ-015 IDLE, start=0: remain in IDLE.
REQ-016 RUN: process one multiplier bit per cycle (shift-add), for exactly WIDTH cycles; then go to FIX.
REQ-017 Signed mode: operate on operand magnitudes (|-2^(WIDTH-1)| = 2^(WIDTH-1), held unsigned).
REQ-018 FIX: negate the product if signed_mode=1 and the operand signs differ; then go to DONE.
REQ-019 On entry to DONE, in the same edge: update result, result_full and overflow; done=1 for one cycle; next state is IDLE.
REQ-020 Latency: define edge 0 as the edge that samples start; done=1 in the cycle after edge WIDTH+1 (WIDTH=8: 10th cycle after the start edge).
REQ-021 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-022 start outside IDLE (including during DONE) is ignored; the operation in flight is unaffected; no queueing.
REQ-023 Unsigned overflow = 1 iff result_full[2*WIDTH-1:WIDTH] != 0.
REQ-024 Signed overflow = 1 iff result_full[2*WIDTH-1:WIDTH-1] is not all-zeros and not all-ones.
REQ-025 result, result_full and overflow hold their values until the next DONE entry; they are unchanged during RUN and FIX.
REQ-026 Operand changes on a and b after the sampling edge SHALL have no effect.
REQ-027 A zero operand still takes full latency; result = 0, overflow = 0.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, force: state IDLE; busy=0; done=0; result=0; result_full=0; overflow=0; internal registers cleared.
REQ-029 Reset asserted mid-operation SHALL abort the operation, with no done pulse for the aborted operation.
REQ-030 The first start is accepted on the first rising edge with rst_n=1.

Verification (WIDTH=8)
REQ-031 Unsigned basics: unsigned 3*4, 15*2 and 10*10 -> result 12, 30 and 100 respectively; overflow=0 for all three; done exactly 10 cycles after the start edge.
REQ-032 Unsigned overflow: unsigned 20*20 -> result_full=400, result=144, overflow=1; unsigned 255*255 -> result_full=65025, result=1, overflow=1.
REQ-033 Signed cases:
- -3*5 -> result_full=16'hFFF1, result=8'hF1, overflow=0.
- -128*-128 -> result_full=16'h4000, result=0, overflow=1.
- -128*1 -> result=8'h80, overflow=0.
REQ-034 Busy rejection: start 7*9, then pulse start with 2*2 during cycle 4 -> single done; result=63.
REQ-035 Reset abort: start 6*7, assert rst_n=0 at cycle 5 -> all outputs 0 at once; no done; then 6*7 after release -> 42.
REQ-036 Back-to-back: start again in the cycle after done -> second result correct; first result held until the second DONE.

Source files
------------

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier (one multiplier bit per cycle) with an unsigned or
// two's-complement mode, a full-width product, a truncated product and overflow.
module mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [2*WIDTH-1:0]   result_full,
  output logic                 overflow
);

  // Handshake: start is a request that is taken only when the block is idle
  // (busy=0 and done=0); it is dropped otherwise. done pulses for one cycle
  // when result, result_full and overflow take their new values.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic               mode;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] fixed;
  logic               ovf_nxt;
  logic               last_bit;

  // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (signed_mode && a[WIDTH-1]) mag_a = -a;
    if (signed_mode && b[WIDTH-1]) mag_b = -b;
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    fixed   = neg ? -acc : acc;
    ovf_nxt = 1'b0;
    if (mode) begin
      ovf_nxt = !((&fixed[2*WIDTH-1:WIDTH-1]) || !(|fixed[2*WIDTH-1:WIDTH-1]));
    end else begin
      ovf_nxt = |fixed[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      neg         <= 1'b0;
      mode        <= 1'b0;
      result      <= '0;
      result_full <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            mode   <= signed_mode;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        FIX: begin
          // Sign fix-up and output update land on the edge that enters DONE.
          result_full <= fixed;
          result      <= fixed[WIDTH-1:0];
          overflow    <= ovf_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq (WIDTH=8): directed operations checked against literals and,
// every cycle, against an arithmetic model of latency, busy/done and held outputs.
module tb_mul_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic [2*W-1:0] result_full;
  logic           overflow;

  int checks = 0;
  int errors = 0;

  mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .result_full(result_full), .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // model: product by plain integer arithmetic
  function automatic longint model_prod(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                        input logic sm);
    longint sa;
    longint sb;
    sa = longint'(ia);
    sb = longint'(ib);
    if (sm && ia[W-1]) sa = sa - (longint'(1) << W);
    if (sm && ib[W-1]) sb = sb - (longint'(1) << W);
    return sa * sb;
  endfunction

  function automatic logic [2*W:0] model_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                            input logic sm);
    longint p;
    longint lim;
    logic   ov;
    p   = model_prod(ia, ib, sm);
    lim = longint'(1) << (W - 1);
    if (sm) ov = (p < -lim) || (p > lim - 1);
    else    ov = (p >= (longint'(1) << W));
    return {ov, p[2*W-1:0]};
  endfunction

  // scoreboard: expected {overflow, full} per accepted operation
  logic [2*W:0] exp_q[$];
  int           m_phase;
  logic [2*W:0] m_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_out   <= '0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (start) begin
        exp_q.push_back(model_op(a, b, signed_mode));
        m_phase <= 1;
      end
    end else if (m_phase == W + 1) begin
      if (exp_q.size() > 0) m_out <= exp_q.pop_front();
      m_phase <= W + 2;
    end else if (m_phase == W + 2) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_busy", 64'(busy), 64'(m_phase >= 1 && m_phase <= W + 1));
      chk("cyc_done", 64'(done), 64'(m_phase == W + 2));
      chk("cyc_full", 64'(result_full), 64'(m_out[2*W-1:0]));
      chk("cyc_result", 64'(result), 64'(m_out[W-1:0]));
      chk("cyc_ovf", 64'(overflow), 64'(m_out[2*W]));
    end
  end

  // driver
  logic [2*W-1:0] last_full;

  task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic sm, input logic [2*W-1:0] e_full, input logic e_ovf);
    int lat;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; signed_mode = sm;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    signed_mode = 1'($urandom_range(0, 1));
    chk({name, "_held"}, 64'(result_full), 64'(last_full));
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(10));
    chk({name, "_full"}, 64'(result_full), 64'(e_full));
    chk({name, "_result"}, 64'(result), 64'(e_full[W-1:0]));
    chk({name, "_ovf"}, 64'(overflow), 64'(e_ovf));
    last_full = e_full;
  endtask

  task automatic chk_zero_now(input string name);
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_done"}, 64'(done), 64'(0));
    chk({name, "_result"}, 64'(result), 64'(0));
    chk({name, "_full"}, 64'(result_full), 64'(0));
    chk({name, "_ovf"}, 64'(overflow), 64'(0));
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    last_full = '0;
    #1;
    chk_zero_now("reset");
    #22;
    rst_n = 1'b1;

    // model pins: hand-computed products
    chk("model_u20x20", 64'(model_op(8'd20, 8'd20, 1'b0)), 64'({1'b1, 16'd400}));
    chk("model_sm3x5", 64'(model_op(8'hFD, 8'd5, 1'b1)), 64'({1'b0, 16'hFFF1}));
    chk("model_s128x128", 64'(model_op(8'h80, 8'h80, 1'b1)), 64'({1'b1, 16'h4000}));

    // back-to-back directed operations
    run_op("u3x4",     8'd3,   8'd4,   1'b0, 16'd12,    1'b0);
    run_op("u15x2",    8'd15,  8'd2,   1'b0, 16'd30,    1'b0);
    run_op("u10x10",   8'd10,  8'd10,  1'b0, 16'd100,   1'b0);
    run_op("u20x20",   8'd20,  8'd20,  1'b0, 16'd400,   1'b1);
    run_op("u255x255", 8'd255, 8'd255, 1'b0, 16'd65025, 1'b1);
    run_op("s_m3x5",   8'hFD,  8'd5,   1'b1, 16'hFFF1,  1'b0);
    run_op("s_m128sq", 8'h80,  8'h80,  1'b1, 16'h4000,  1'b1);
    run_op("s_m128x1", 8'h80,  8'd1,   1'b1, 16'hFF80,  1'b0);
    run_op("s_m1xm1",  8'hFF,  8'hFF,  1'b1, 16'h0001,  1'b0);
    run_op("s_127xm1", 8'd127, 8'hFF,  1'b1, 16'hFF81,  1'b0);
    run_op("s_12x11",  8'd12,  8'd11,  1'b1, 16'd132,   1'b1);
    run_op("u_0x77",   8'd0,   8'd77,  1'b0, 16'd0,     1'b0);
    run_op("s_0xm5",   8'd0,   8'hFB,  1'b1, 16'd0,     1'b0);

    // start during an operation is dropped
    @(negedge clk);
    start = 1'b1; a = 8'd7; b = 8'd9; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'd2; b = 8'd2;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("reject_dones", 64'(ndone), 64'(1));
    chk("reject_result", 64'(result), 64'(63));
    last_full = 16'd63;

    // reset in flight
    @(negedge clk);
    start = 1'b1; a = 8'd6; b = 8'd7; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_now("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_full = '0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'(0));
    chk("abort_full", 64'(result_full), 64'(0));
    run_op("u6x7", 8'd6, 8'd7, 1'b0, 16'd42, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
